// File: rtl/vga_frame_sink.sv
// Pixel-stream sink: recovers X/Y and per-frame geometry, match count and checksum.
// Bounding-box tracking of TARGET pixels is built only with `define VGA_SINK_BBOX_EN.
module vga_frame_sink #(
    parameter int unsigned H_MAX    = 640,
    parameter int unsigned V_MAX    = 480,
    parameter bit          SYNC_POL = 1'b0,
    parameter logic [15:0] TARGET   = 16'hF800
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst,
    input  logic        vsync,
    input  logic        de,
    input  logic [15:0] colour,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_done,
    output logic [9:0]  frame_w,
    output logic [9:0]  frame_h,
    output logic [18:0] match_cnt,
    output logic [15:0] checksum,
    output logic        geom_err,
    output logic [9:0]  bb_x0,
    output logic [9:0]  bb_y0,
    output logic [9:0]  bb_x1,
    output logic [9:0]  bb_y1
);

    localparam logic [10:0] HMAX_W = 11'(H_MAX);
    localparam logic [10:0] VMAX_W = 11'(V_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_REPORT
    } state_t;

    // ---------------- input stage ----------------
    logic        vs_q, vs2_q;
    logic        de_q, de2_q;
    logic [15:0] col_q;
    logic [9:0]  x_q, x_d;
    logic [9:0]  ln_q, ln_d;
    logic [9:0]  py_q, py_d;
    logic        vs_in_edge;
    logic        de_in_rise;
    logic        de_in_fall;

    assign vs_in_edge = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    assign de_in_rise = de && !de_q;
    assign de_in_fall = !de && de_q;

    always_comb begin
        x_d = x_q;
        if (de_in_rise) begin
            x_d = '0;
        end else if (de && (x_q != '1)) begin
            x_d = x_q + 10'd1;
        end
    end

    // Line counter moves between lines; pix_y only follows it while de is high.
    always_comb begin
        ln_d = ln_q;
        if (vs_in_edge) begin
            ln_d = '0;
        end else if (de_in_fall && (ln_q != '1)) begin
            ln_d = ln_q + 10'd1;
        end
    end

    always_comb begin
        py_d = py_q;
        if (de) begin
            py_d = vs_in_edge ? 10'd0 : ln_q;
        end
    end

    always_ff @(posedge Clk_int) begin
        if (Sys_Rst) begin
            vs_q  <= SYNC_POL;
            vs2_q <= SYNC_POL;
            de_q  <= 1'b0;
            de2_q <= 1'b0;
            col_q <= '0;
            x_q   <= '0;
            ln_q  <= '0;
            py_q  <= '0;
        end else begin
            vs_q  <= vsync;
            vs2_q <= vs_q;
            de_q  <= de;
            de2_q <= de_q;
            col_q <= colour;
            x_q   <= x_d;
            ln_q  <= ln_d;
            py_q  <= py_d;
        end
    end

    assign pix_valid = de_q;
    assign pix_x     = x_q;
    assign pix_y     = py_q;

    // ---------------- accumulator stage ----------------
    state_t      state_q;
    logic        vs_edge;
    logic        de_fall;
    logic        hit;
    logic        frame_open;
    logic        frame_close;
    logic [10:0] line_w;

    assign vs_edge     = (vs_q == SYNC_POL) && (vs2_q != SYNC_POL);
    assign de_fall     = !de_q && de2_q;
    assign hit         = de_q && (col_q == TARGET);
    assign frame_open  = vs_edge && (state_q != S_REPORT);
    assign frame_close = vs_edge && (state_q == S_FRAME);
    assign line_w      = {1'b0, x_q} + 11'd1;

    logic        first_q, first_d;
    logic [10:0] w_q, w_d;
    logic [9:0]  h_q, h_d;
    logic        err_q, err_d;
    logic [18:0] m_q, m_d;
    logic [15:0] chk_q, chk_d;

    // A pixel coincident with the opening edge loads into the fresh frame.
    always_comb begin
        first_d = first_q;
        w_d     = w_q;
        h_d     = h_q;
        err_d   = err_q;
        m_d     = m_q;
        chk_d   = chk_q;
        if (frame_open) begin
            first_d = 1'b1;
            w_d     = '0;
            h_d     = '0;
            err_d   = 1'b0;
            m_d     = '0;
            chk_d   = '0;
        end else if (de_fall) begin
            if (h_q != '1) begin
                h_d = h_q + 10'd1;
            end
            if ({1'b0, h_d} > VMAX_W) begin
                err_d = 1'b1;
            end
            if (first_q) begin
                first_d = 1'b0;
                w_d     = line_w;
            end else if (line_w != w_q) begin
                err_d = 1'b1;
            end
            if (line_w > HMAX_W) begin
                err_d = 1'b1;
            end
        end
        if (de_q) begin
            chk_d = {chk_d[14:0], chk_d[15]} ^ col_q;
            if (hit && (m_d != '1)) begin
                m_d = m_d + 19'd1;
            end
        end
    end

    always_ff @(posedge Clk_int) begin
        if (Sys_Rst) begin
            first_q <= 1'b1;
            w_q     <= '0;
            h_q     <= '0;
            err_q   <= 1'b0;
            m_q     <= '0;
            chk_q   <= '0;
        end else begin
            first_q <= first_d;
            w_q     <= w_d;
            h_q     <= h_d;
            err_q   <= err_d;
            m_q     <= m_d;
            chk_q   <= chk_d;
        end
    end

    // ---------------- frame FSM and result registers ----------------
    logic        done_q;
    logic [9:0]  res_w_q;
    logic [9:0]  res_h_q;
    logic [18:0] res_m_q;
    logic [15:0] res_chk_q;
    logic        res_err_q;

    always_ff @(posedge Clk_int) begin
        if (Sys_Rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            res_w_q   <= '0;
            res_h_q   <= '0;
            res_m_q   <= '0;
            res_chk_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (vs_edge) begin
                        state_q <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (vs_edge) begin
                        state_q   <= S_REPORT;
                        done_q    <= 1'b1;
                        res_w_q   <= w_q[10] ? 10'h3FF : w_q[9:0];
                        res_h_q   <= h_q;
                        res_m_q   <= m_q;
                        res_chk_q <= chk_q;
                        res_err_q <= err_q;
                    end
                end
                S_REPORT: begin
                    state_q <= S_FRAME;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_done = done_q;
    assign frame_w    = res_w_q;
    assign frame_h    = res_h_q;
    assign match_cnt  = res_m_q;
    assign checksum   = res_chk_q;
    assign geom_err   = res_err_q;

`ifdef VGA_SINK_BBOX_EN
    logic [9:0] bx0_q, bx0_d;
    logic [9:0] by0_q, by0_d;
    logic [9:0] bx1_q, bx1_d;
    logic [9:0] by1_q, by1_d;
    logic [9:0] rx0_q, ry0_q, rx1_q, ry1_q;

    always_comb begin
        bx0_d = bx0_q;
        by0_d = by0_q;
        bx1_d = bx1_q;
        by1_d = by1_q;
        if (frame_open) begin
            bx0_d = '1;
            by0_d = '1;
            bx1_d = '0;
            by1_d = '0;
        end
        if (hit) begin
            if (x_q < bx0_d) bx0_d = x_q;
            if (x_q > bx1_d) bx1_d = x_q;
            if (py_q < by0_d) by0_d = py_q;
            if (py_q > by1_d) by1_d = py_q;
        end
    end

    always_ff @(posedge Clk_int) begin
        if (Sys_Rst) begin
            bx0_q <= '1;
            by0_q <= '1;
            bx1_q <= '0;
            by1_q <= '0;
            rx0_q <= '0;
            ry0_q <= '0;
            rx1_q <= '0;
            ry1_q <= '0;
        end else begin
            bx0_q <= bx0_d;
            by0_q <= by0_d;
            bx1_q <= bx1_d;
            by1_q <= by1_d;
            if (frame_close) begin
                rx0_q <= bx0_q;
                ry0_q <= by0_q;
                rx1_q <= bx1_q;
                ry1_q <= by1_q;
            end
        end
    end

    assign bb_x0 = rx0_q;
    assign bb_y0 = ry0_q;
    assign bb_x1 = rx1_q;
    assign bb_y1 = ry1_q;
`else
    assign bb_x0 = '0;
    assign bb_y0 = '0;
    assign bb_x1 = '0;
    assign bb_y1 = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sink.sv
// Directed bench for vga_frame_sink on a reduced 16x12 raster.
// Frame reports and pixel coordinates are checked against scoreboard queues.
module tb_vga_frame_sink;

    localparam int          W   = 16;
    localparam int          H   = 12;
    localparam logic [15:0] TGT = 16'hF800;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        de;
    logic [15:0] colour;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;
    logic        frame_done;
    logic [9:0]  frame_w, frame_h;
    logic [18:0] match_cnt;
    logic [15:0] checksum;
    logic        geom_err;
    logic [9:0]  bb_x0, bb_y0, bb_x1, bb_y1;

    vga_frame_sink #(
        .H_MAX   (W),
        .V_MAX   (H),
        .SYNC_POL(1'b0),
        .TARGET  (TGT)
    ) dut (
        .Clk_int   (clk),
        .Sys_Rst   (rst),
        .vsync     (vsync),
        .de        (de),
        .colour    (colour),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_done(frame_done),
        .frame_w   (frame_w),
        .frame_h   (frame_h),
        .match_cnt (match_cnt),
        .checksum  (checksum),
        .geom_err  (geom_err),
        .bb_x0     (bb_x0),
        .bb_y0     (bb_y0),
        .bb_x1     (bb_x1),
        .bb_y1     (bb_y1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int w, h, m, chk, err;
        int bx0, by0, bx1, by1;
        int cyc;
    } exp_t;

    exp_t eq[$];
    int   qx[$];
    int   qy[$];

    int nchk = 0;
    int nerr = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model state
    int          mst = 0;
    bit          prev_vs = 1'b1;
    bit          prev_de = 1'b0;
    int          run = 0;
    int          vs_left = 0;
    bit          m_first;
    int          m_w, m_h, m_m, m_err;
    logic [15:0] m_chk;
    int          m_bx0, m_by0, m_bx1, m_by1;

    task automatic model_open(int done_cyc);
        exp_t e;
        if (mst == 1) begin
            e.w   = m_w;
            e.h   = m_h;
            e.m   = m_m;
            e.chk = int'(m_chk);
            e.err = m_err;
`ifdef VGA_SINK_BBOX_EN
            e.bx0 = m_bx0;
            e.by0 = m_by0;
            e.bx1 = m_bx1;
            e.by1 = m_by1;
`else
            e.bx0 = 0;
            e.by0 = 0;
            e.bx1 = 0;
            e.by1 = 0;
`endif
            e.cyc = done_cyc;
            eq.push_back(e);
        end
        mst     = 1;
        m_first = 1'b1;
        m_w     = 0;
        m_h     = 0;
        m_m     = 0;
        m_err   = 0;
        m_chk   = 16'h0000;
        m_bx0   = 1023;
        m_by0   = 1023;
        m_bx1   = 0;
        m_by1   = 0;
    endtask

    task automatic model_line_end();
        m_h++;
        if (m_h > H) m_err = 1;
        if (m_first) begin
            m_w     = run;
            m_first = 1'b0;
        end else if (run != m_w) begin
            m_err = 1;
        end
        if (run > W) m_err = 1;
        run = 0;
    endtask

    task automatic drive(bit d, logic [15:0] c, int x, int y);
        bit v;
        v = (vs_left > 0) ? 1'b0 : 1'b1;
        if (vs_left > 0) vs_left--;
        if (!v && prev_vs) begin
            model_open(cyc + 2);
        end else if (!d && prev_de) begin
            model_line_end();
        end
        prev_vs = v;
        prev_de = d;
        if (d) begin
            run++;
            m_chk = {m_chk[14:0], m_chk[15]} ^ c;
            if (c == TGT) begin
                m_m++;
                if (x < m_bx0) m_bx0 = x;
                if (x > m_bx1) m_bx1 = x;
                if (y < m_by0) m_by0 = y;
                if (y > m_by1) m_by1 = y;
            end
            qx.push_back(x);
            qy.push_back(y);
        end
        vsync  = v;
        de     = d;
        colour = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string ph);
        check({ph, "_pix_valid"}, 32'(pix_valid), 0);
        check({ph, "_pix_x"}, 32'(pix_x), 0);
        check({ph, "_pix_y"}, 32'(pix_y), 0);
        check({ph, "_frame_done"}, 32'(frame_done), 0);
        check({ph, "_frame_w"}, 32'(frame_w), 0);
        check({ph, "_frame_h"}, 32'(frame_h), 0);
        check({ph, "_match_cnt"}, 32'(match_cnt), 0);
        check({ph, "_checksum"}, 32'(checksum), 0);
        check({ph, "_geom_err"}, 32'(geom_err), 0);
        check({ph, "_bb_x0"}, 32'(bb_x0), 0);
        check({ph, "_bb_y0"}, 32'(bb_y0), 0);
        check({ph, "_bb_x1"}, 32'(bb_x1), 0);
        check({ph, "_bb_y1"}, 32'(bb_y1), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        de  = 1'b0;
        @(posedge clk);
        #1;
        check_zero("midrst");
        rst     = 1'b0;
        mst     = 0;
        run     = 0;
        prev_de = 1'b0;
        qx.delete();
        qy.delete();
    endtask

    function automatic logic [15:0] colour_of(int mode, int x, int y, int tx, int ty);
        logic [15:0] c;
        c = 16'h0000;
        if (mode == 0) begin
            c = TGT;
        end else if (mode == 1) begin
            c = (x == tx && y == ty) ? TGT : 16'h0000;
        end else if (mode == 3) begin
            c = ((x + y) % 5 == 0) ? TGT : (16'(x * 37 + y * 1031) ^ 16'h5A5A);
        end
        return c;
    endfunction

    // One frame: vsync pulse (or vsync coincident with line 0), then nl lines.
    task automatic frame(int mode, int tx, int ty, int wd, int short_ln,
                         int nl, int rst_at, bit coincide);
        int yo;
        int n;
        yo      = 0;
        vs_left = 2;
        if (!coincide) begin
            repeat (4) drive(1'b0, 16'h0000, 0, 0);
        end
        for (int y = 0; y < nl; y++) begin
            n = (y == short_ln) ? wd - 1 : wd;
            if (y == rst_at) begin
                do_reset();
                yo = y;
            end
            for (int x = 0; x < n; x++) begin
                drive(1'b1, colour_of(mode, x, y, tx, ty), x, y - yo);
            end
            repeat (4) drive(1'b0, 16'h0000, 0, 0);
        end
        repeat (2) drive(1'b0, 16'h0000, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && pix_valid) begin
            if (qx.size() == 0) begin
                check("pix_valid_spurious", 32'(pix_valid), 0);
            end else begin
                check("pix_x", 32'(pix_x), qx.pop_front());
                check("pix_y", 32'(pix_y), qy.pop_front());
            end
        end
        if (!rst && frame_done) begin
            if (eq.size() == 0) begin
                check("frame_done_spurious", 32'(frame_done), 0);
            end else begin
                e = eq.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("frame_w", 32'(frame_w), e.w);
                check("frame_h", 32'(frame_h), e.h);
                check("match_cnt", 32'(match_cnt), e.m);
                check("checksum", 32'(checksum), e.chk);
                check("geom_err", 32'(geom_err), e.err);
                check("bb_x0", 32'(bb_x0), e.bx0);
                check("bb_y0", 32'(bb_y0), e.by0);
                check("bb_x1", 32'(bb_x1), e.bx1);
                check("bb_y1", 32'(bb_y1), e.by1);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        vsync  = 1'b1;
        de     = 1'b0;
        colour = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        repeat (4) drive(1'b0, 16'h0000, 0, 0);

        // all-target frames; first vsync after reset only opens
        frame(0, 0, 0, W, -1, H, -1, 1'b0);
        frame(0, 0, 0, W, -1, H, -1, 1'b0);
        // black with single target pixel
        frame(1, 9, 7, W, -1, H, -1, 1'b0);
        // mixed pattern for checksum coverage
        frame(3, 0, 0, W, -1, H, -1, 1'b0);
        // line 5 one pixel short
        frame(0, 0, 0, W, 5, H, -1, 1'b0);
        // clean all-black frame
        frame(2, 0, 0, W, -1, H, -1, 1'b0);
        // every line one pixel over H_MAX
        frame(0, 0, 0, W + 1, -1, H, -1, 1'b0);
        // one line more than V_MAX
        frame(3, 0, 0, W, -1, H + 1, -1, 1'b0);
        // reset in the middle of a frame
        frame(2, 0, 0, W, -1, H, 6, 1'b0);
        frame(3, 0, 0, W, -1, H, -1, 1'b0);
        frame(2, 0, 0, W, -1, H, -1, 1'b0);
        // vsync edge coincident with first target pixel
        frame(1, 0, 0, W, -1, H, -1, 1'b1);

        vs_left = 2;
        repeat (6) drive(1'b0, 16'h0000, 0, 0);
        for (int i = 0; i < 20 && eq.size() > 0; i++) begin
            drive(1'b0, 16'h0000, 0, 0);
        end
        check("reports_pending", eq.size(), 0);
        check("pixels_pending", qx.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
